keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scanning reader for a 4x4 matrix keypad (Pmod KYPD layout): drives one column low at a time, samples the four row lines, debounces over whole scan frames and emits one hex key code per press. It is the input-side counterpart of the multiplexed seven-segment display driver: `key_valid` replaces the debounced button pulse as the `add1` source, and `key_code` feeds the digit registers and the seven-segment decoder directly.

## Interface
- `SCAN_TICKS`, default 100_000: clk cycles each column is driven (1 ms at 100 MHz); legal range ≥ 4.
- `DEBOUNCE_FRAMES`, default 4: consecutive identical frames required to accept a press or a release; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `row` in 4: row sense lines, active-low (pulled up externally), asynchronous to `clk`.
- `col` out 4: column drive, active-low, exactly one bit low at all times.
- `key_code` out 4: hex value of the last accepted key; held until the next accepted key.
- `key_valid` out 1: one-cycle pulse when a press is accepted.
- `key_down` out 1: level, high while an accepted key is considered held.

## Operation
- `row` passes through a 2-flop synchronizer before use.
- Tick generator counts 0..SCAN_TICKS-1 and wraps. Terminal count is `tick`.
- Column index `c` is 0..3, with `col = ~(1<<c)`. On `tick`, synchronized rows are sampled into frame bits `[r*4+c]` (pressed = row bit low), then `c` advances with wrap 3→0.
- A frame is 4 ticks. `frame_end` is the tick with c==3.
- At `frame_end`, the candidate is the lowest pressed index `r*4+c` in the frame. `none` means no bit is set. Multiple keys resolve to the lowest index.
- Key map, rows 0..3, columns 0..3 (code = hex value): 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
- FSM (evaluated only at `frame_end`):
  - IDLE: candidate present → PRESS_DB, latch candidate, count=1. If DEBOUNCE_FRAMES==1, go straight to accept.
  - PRESS_DB:
    - same candidate → count+1; when count reaches DEBOUNCE_FRAMES → HELD (accept).
    - different candidate → stay, relatch, count=1.
    - none → IDLE.
  - HELD: none → REL_DB, count=1 (DEBOUNCE_FRAMES==1 → IDLE). Any key present → stay, with no new pulse; this includes other keys, so there is no rollover.
  - REL_DB: none → count+1; when count reaches DEBOUNCE_FRAMES → IDLE. Any key → HELD, with no pulse.
- Accept:
  - `key_code` ← map(candidate).
  - `key_valid` = 1 for one cycle.
  - `key_down` = 1 in HELD and REL_DB, 0 otherwise.
- Count register is 4 bits and saturates. No arithmetic wraps beyond the stated ranges.

## Timing
- Reset values:
  - `col` = 4'b1110.
  - `key_code` = 0.
  - `key_valid` = 0.
  - `key_down` = 0.
  - FSM = IDLE; tick counter, column index, frame bits and count = 0.
- Reset asserted mid-frame or mid-debounce returns all state to these values immediately, with no output pulse.
- Row sampling happens SCAN_TICKS-1 cycles after the column changes. This exceeds the 2-cycle synchronizer latency plus settle time.
- Press latency: `key_valid` is registered high the cycle after the `frame_end` of the DEBOUNCE_FRAMES-th consecutive matching frame. `key_code` updates on the same edge. `key_down` rises on that edge.
- `key_down` falls the cycle after the `frame_end` of the DEBOUNCE_FRAMES-th consecutive empty frame.
- `key_valid` never asserts on two consecutive cycles. Its minimum spacing is 2·DEBOUNCE_FRAMES frames.

## Structure
- Shared package holds:
  - the 16-entry key map constant;
  - the FSM state type (IDLE, PRESS_DB, HELD, REL_DB);
  - the `none` candidate encoding (5-bit candidate, MSB = none).
- Sub-module `scan_tick`: parameterised terminal-count tick generator (SCAN_TICKS), producing `tick`. The same block can serve the display refresh enable.
- Top level holds the synchronizer, column index, frame register, priority encoder and FSM.

## Test plan
All scenarios use SCAN_TICKS=8 and DEBOUNCE_FRAMES=3, so 1 frame = 32 cycles.
- **Reset:** hold `reset`=0 → `col`=1110, `key_code`=0, `key_valid`=0, `key_down`=0. After release, `col` steps 1110→1101→1011→0111→1110 every 8 cycles.
- **Single press:** model a switch at row1/col2 (pulls row[1] low while col[2] is low) for 6 frames → exactly one `key_valid` pulse with `key_code`=6, one cycle after the 3rd frame end. `key_down` falls 3 empty frames after release.
- **Bounce:** toggle row3/col0 on alternate frames for 10 frames, then hold → no pulse during toggling. Exactly one pulse with `key_code`=0 after 3 stable frames.
- **Simultaneous:** hold row0/col3 (A) and row2/col1 (8) together → one pulse, `key_code`=0xA (index 3 < 9). Releasing A while 8 stays held → no new pulse.
- **Short release:** in HELD, release for 2 frames then re-press → no second pulse, `key_down` stays 1.
- **Reset mid-debounce:** assert `reset` after 2 matching frames, deassert, keep holding the key → `key_valid` appears only after 3 full frames counted from reset release.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: key map, FSM state type and candidate encoding shared by the keypad scanner.
package keypad_scanner_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
  localparam logic [4:0] CAND_NONE = 5'b10000;
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };
endpackage

// File: rtl/keypad_scanner_tick.sv
// scan_tick: terminal-count tick generator, one pulse every SCAN_TICKS cycles.
module scan_tick #(
  parameter int SCAN_TICKS = 100_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int W = $clog2(SCAN_TICKS);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(SCAN_TICKS - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame-based debounce, one hex code per press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_TICKS      = 100_000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);
  localparam logic [3:0] DB = 4'(DEBOUNCE_FRAMES);
  logic [3:0] row_meta, row_sync;
  logic tick, frame_end, accept;
  logic [1:0] c;
  logic [15:0] frame, frame_next;
  logic [4:0] cand;
  logic [3:0] cnt, cnt_n, cnt_inc, lat, lat_n;
  state_t state, state_n;

  scan_tick #(.SCAN_TICKS(SCAN_TICKS)) u_tick (.clk(clk), .reset(reset), .tick(tick));

  assign col = ~(4'b0001 << c);
  assign frame_end = tick && c == 2'd3;
  assign key_down = state == HELD || state == REL_DB;
  assign cnt_inc = cnt == 4'hF ? cnt : cnt + 4'd1;

  // the candidate must include the column being sampled on this tick
  always_comb begin
    frame_next = frame;
    for (int r = 0; r < 4; r++) frame_next[{2'(r), c}] = ~row_sync[r];
  end

  always_comb begin
    cand = CAND_NONE;
    for (int i = 15; i >= 0; i--) if (frame_next[i]) cand = {1'b0, 4'(i)};
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      row_meta <= '1;
      row_sync <= '1;
      c <= '0;
      frame <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      if (tick) begin
        frame <= frame_next;
        c <= c + 2'd1;
      end
    end

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    lat_n = lat;
    accept = 1'b0;
    if (frame_end)
      case (state)
        IDLE:
          if (!cand[4]) begin
            lat_n = cand[3:0];
            cnt_n = 4'd1;
            accept = DB == 4'd1;
            state_n = DB == 4'd1 ? HELD : PRESS_DB;
          end
        PRESS_DB:
          if (cand[4]) begin
            state_n = IDLE;
            cnt_n = '0;
          end else if (cand[3:0] == lat) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= DB) begin
              state_n = HELD;
              accept = 1'b1;
            end
          end else begin
            lat_n = cand[3:0];
            cnt_n = 4'd1;
          end
        HELD:
          if (cand[4]) begin
            state_n = DB == 4'd1 ? IDLE : REL_DB;
            cnt_n = DB == 4'd1 ? 4'd0 : 4'd1;
          end
        REL_DB:
          if (cand[4]) begin
            cnt_n = cnt_inc >= DB ? 4'd0 : cnt_inc;
            state_n = cnt_inc >= DB ? IDLE : REL_DB;
          end else begin
            state_n = HELD;
            cnt_n = '0;
          end
      endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      lat <= '0;
      key_valid <= 1'b0;
      key_code <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      lat <= lat_n;
      key_valid <= accept;
      key_code <= accept ? KEY_MAP[lat_n] : key_code;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed frame table, reset corner cases and randomized key patterns vs a frame-level model.
`timescale 1ns/1ps
module tb_keypad_scanner;
  localparam int DB = 3;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] row, col, key_code;
  logic key_valid, key_down;
  logic [15:0] keys = '0;
  int n_cmp = 0, n_bad = 0;
  logic exp_down_q = 1'b0;
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
  typedef struct {logic [15:0] k; logic v; logic [3:0] code; logic d;} vec_t;
  vec_t tbl[$];
  logic m_down;
  int m_run_key, m_run_len, m_empty;
  logic [3:0] m_code;

  always #5 clk = ~clk;

  // switch matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++)
        if (keys[r*4+q] && !col[q]) row[r] = 1'b0;
  end

  keypad_scanner #(.SCAN_TICKS(8), .DEBOUNCE_FRAMES(DB)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(input logic [15:0] k, input logic ev, input logic [3:0] ec, input logic ed);
    logic [3:0] ecol;
    keys = k;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      ecol = ~(4'b0001 << (((i + 1) / 8) % 4));
      chk("col", col, ecol);
      if (i < 31) begin
        chk("key_valid_mid", key_valid, 1'b0);
        chk("key_down_mid", key_down, exp_down_q);
      end else begin
        chk("key_valid_end", key_valid, ev);
        chk("key_code_end", key_code, ec);
        chk("key_down_end", key_down, ed);
      end
    end
    exp_down_q = ed;
  endtask

  task automatic model_step(input logic [15:0] k, output logic v);
    int cand = -1;
    for (int i = 15; i >= 0; i--) if (k[i]) cand = i;
    v = 1'b0;
    if (!m_down) begin
      if (cand < 0) m_run_len = 0;
      else begin
        if (m_run_len > 0 && cand == m_run_key) m_run_len++;
        else begin
          m_run_key = cand;
          m_run_len = 1;
        end
        if (m_run_len == DB) begin
          m_down = 1'b1;
          v = 1'b1;
          m_code = kmap[cand];
          m_empty = 0;
          m_run_len = 0;
        end
      end
    end else if (cand < 0) begin
      m_empty++;
      if (m_empty == DB) m_down = 1'b0;
    end else m_empty = 0;
  endtask

  function automatic vec_t mk(input logic [15:0] k, input logic v, input logic [3:0] code, input logic d);
    vec_t t;
    t.k = k; t.v = v; t.code = code; t.d = d;
    return t;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ev;
    logic [15:0] rk;
    // single press of 6, release
    for (int i = 0; i < 6; i++) tbl.push_back(mk(16'h0040, i == 2, i >= 2 ? 4'h6 : 4'h0, i >= 2));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(16'h0000, 1'b0, 4'h6, i < 2));
    // bouncing 0 key, then stable
    for (int i = 0; i < 10; i++) tbl.push_back(mk(i % 2 == 0 ? 16'h1000 : 16'h0000, 1'b0, 4'h6, 1'b0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h1000, i == 2, i == 2 ? 4'h0 : 4'h6, i == 2));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h0000, 1'b0, 4'h0, i < 2));
    // A and 8 together, A released, short release, re-press
    for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h0208, i == 2, i == 2 ? 4'hA : 4'h0, i == 2));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h0200, 1'b0, 4'hA, 1'b1));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(16'h0000, 1'b0, 4'hA, 1'b1));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(16'h0200, 1'b0, 4'hA, 1'b1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h0000, 1'b0, 4'hA, i < 2));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_col", col, 4'b1110);
    chk("reset_code", key_code, 4'h0);
    chk("reset_valid", key_valid, 1'b0);
    chk("reset_down", key_down, 1'b0);
    reset = 1'b1;
    foreach (tbl[i]) run_frame(tbl[i].k, tbl[i].v, tbl[i].code, tbl[i].d);

    // reset after two matching frames restarts the debounce count
    run_frame(16'h0020, 1'b0, 4'hA, 1'b0);
    run_frame(16'h0020, 1'b0, 4'hA, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_col", col, 4'b1110);
    chk("midrst_code", key_code, 4'h0);
    chk("midrst_valid", key_valid, 1'b0);
    chk("midrst_down", key_down, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_down_q = 1'b0;
    run_frame(16'h0020, 1'b0, 4'h0, 1'b0);
    run_frame(16'h0020, 1'b0, 4'h0, 1'b0);
    run_frame(16'h0020, 1'b1, 4'h5, 1'b1);
    for (int i = 0; i < 3; i++) run_frame(16'h0000, 1'b0, 4'h5, i < 2);

    // randomized key patterns against the frame-level model
    m_down = 1'b0; m_run_key = 0; m_run_len = 0; m_empty = 0; m_code = 4'h5;
    rk = '0;
    for (int f = 0; f < 90; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        rk = '0;
        repeat ($urandom_range(0, 2)) rk[$urandom_range(0, 15)] = 1'b1;
      end
      model_step(rk, ev);
      run_frame(rk, ev, m_code, m_down);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
